// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI responder types and helpers.
//   spi_rsp_state_e : responder FSM states
//   RW_BIT          : position of the read/write flag in the command byte
//   cpol()/cpha()   : decode clock polarity / phase from an SPI_MODE value (0..3)
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } spi_rsp_state_e;

  localparam int RW_BIT = 7;

  function automatic logic cpol(input int spi_mode);
    return spi_mode[1];
  endfunction

  function automatic logic cpha(input int spi_mode);
    return spi_mode[0];
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: brings the asynchronous SPI pad signals into the clk domain
// and turns SCLK transitions into single-cycle sample/shift strobes.
//   clk, rst_n    : system clock, async active-low reset
//   sclk, cs, mosi: raw pad inputs
//   cs_fall       : 1-clk pulse when the synced chip select goes low
//   cs_rise       : 1-clk pulse when the synced chip select goes high
//   sample_pulse  : 1-clk pulse on the SCLK edge where MOSI is captured
//   shift_pulse   : 1-clk pulse on the SCLK edge where MISO advances
//   mosi_s        : synced MOSI, aligned with the strobes
// Parameter SPI_MODE selects CPOL/CPHA.
module spi_edge_sync
  import spi_pkg::*;
#(
  parameter int SPI_MODE = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs,
  input  logic mosi,
  output logic cs_fall,
  output logic cs_rise,
  output logic sample_pulse,
  output logic shift_pulse,
  output logic mosi_s
);

  localparam logic CPOL = cpol(SPI_MODE);
  localparam logic CPHA = cpha(SPI_MODE);

  // [0],[1] form the synchroniser; [2] holds the previous synced value for edge detect
  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      cs_q   <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      cs_q   <= {cs_q[1:0], cs};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  logic sclk_rise, sclk_fall, lead_edge, trail_edge, cs_low;

  assign sclk_rise  = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall  = ~sclk_q[1] & sclk_q[2];
  assign lead_edge  = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge = CPOL ? sclk_rise : sclk_fall;
  assign cs_low     = ~cs_q[1];

  // mosi_q[1] has the same latency as sclk_q[1], so it is the value at the edge
  assign sample_pulse = cs_low & (CPHA ? trail_edge : lead_edge);
  assign shift_pulse  = cs_low & (CPHA ? lead_edge : trail_edge);
  assign cs_fall      = cs_q[2] & ~cs_q[1];
  assign cs_rise      = ~cs_q[2] & cs_q[1];
  assign mosi_s       = mosi_q[1];

endmodule

// File: rtl/spi_slave_reg_responder.sv
// spi_slave_reg_responder: SPI responder that serves a local register file.
// Frame: byte0 = {rw, addr[6:0]} (rw=1 read), byte1 = data, MSB first.
//   clk, rst_n           : system clock, async active-low reset
//   sclk, cs, mosi       : SPI pads from the master (async, cs active low)
//   miso, miso_oe        : read data out and its drive enable
//   reg_wr_valid/addr/data: 1-clk commit strobe for SPI writes
//   host_addr, host_rdata: combinational local read port (0 when out of range)
//   frame_done, frame_err: 1-clk status pulse at the end of every frame
// Optional build macro SPI_REG_AUTO_INC_EN: data bytes keep flowing with the
// address incrementing after each byte instead of draining after one byte.
//
// state | meaning
// IDLE  | waiting for chip select to fall
// CMD   | shifting in the command byte
// DATA  | shifting data in (write) or out (read)
// DRAIN | transfer complete, remaining bits ignored until cs rises
module spi_slave_reg_responder
  import spi_pkg::*;
#(
  parameter int SPI_MODE    = 1,
  parameter int SPI_TRF_BIT = 8,
  parameter int NUM_REGS    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sclk,
  input  logic                   cs,
  input  logic                   mosi,
  output logic                   miso,
  output logic                   miso_oe,
  output logic                   reg_wr_valid,
  output logic [6:0]             reg_wr_addr,
  output logic [SPI_TRF_BIT-1:0] reg_wr_data,
  input  logic [6:0]             host_addr,
  output logic [SPI_TRF_BIT-1:0] host_rdata,
  output logic                   frame_done,
  output logic                   frame_err
);

`ifdef SPI_REG_AUTO_INC_EN
  localparam bit AUTO_INC = 1'b1;
`else
  localparam bit AUTO_INC = 1'b0;
`endif

  localparam int W     = SPI_TRF_BIT;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int SLOTS = 1 << IDX_W;
  localparam int CNT_W = $clog2(SPI_TRF_BIT + 1);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(SPI_TRF_BIT - 1);
  localparam logic [7:0]       NUM_REGS_W = 8'(NUM_REGS);

  logic cs_fall, cs_rise, sample_pulse, shift_pulse, mosi_s;

  spi_edge_sync #(.SPI_MODE(SPI_MODE)) u_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .sclk         (sclk),
    .cs           (cs),
    .mosi         (mosi),
    .cs_fall      (cs_fall),
    .cs_rise      (cs_rise),
    .sample_pulse (sample_pulse),
    .shift_pulse  (shift_pulse),
    .mosi_s       (mosi_s)
  );

  spi_rsp_state_e   state_q, state_d;
  logic [CNT_W-1:0] bit_cnt;
  logic [W-2:0]     shift_in;
  logic [W-1:0]     shift_out;
  logic [W-1:0]     rx_word;
  logic [6:0]       addr;
  logic [6:0]       next_addr;
  logic             rw;
  logic             err;
  logic             data_done;
  logic             byte_end;
  logic             frame_ok;
  logic [W-1:0]     regs [SLOTS];

  function automatic logic addr_ok(input logic [6:0] a);
    return {1'b0, a} < NUM_REGS_W;
  endfunction

  function automatic logic [W-1:0] fetch(input logic [6:0] a);
    if (addr_ok(a)) return regs[a[IDX_W-1:0]];
    return '1;
  endfunction

  assign rx_word   = {shift_in, mosi_s};
  assign byte_end  = sample_pulse && (bit_cnt == LAST_BIT);
  assign next_addr = addr + 7'd1;
  // bit_cnt != 0 means a byte was cut short by cs rising
  assign frame_ok  = data_done && !err && (bit_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = CMD;
      CMD:     if (byte_end) state_d = DATA;
      DATA:    if (byte_end && !AUTO_INC) state_d = DRAIN;
      DRAIN:   state_d = DRAIN;
      default: state_d = IDLE;
    endcase
    if (cs_rise) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      shift_in     <= '0;
      shift_out    <= '0;
      addr         <= '0;
      rw           <= 1'b0;
      err          <= 1'b0;
      data_done    <= 1'b0;
      miso         <= 1'b0;
      miso_oe      <= 1'b0;
      reg_wr_valid <= 1'b0;
      reg_wr_addr  <= '0;
      reg_wr_data  <= '0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
      for (int i = 0; i < SLOTS; i++) regs[i] <= '0;
    end else begin
      reg_wr_valid <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;

      // Commit one clk after the strobe so host reads see the old value while it is high
      if (reg_wr_valid) regs[reg_wr_addr[IDX_W-1:0]] <= reg_wr_data;

      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            bit_cnt   <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            err       <= 1'b0;
            data_done <= 1'b0;
            miso      <= 1'b0;
            miso_oe   <= 1'b1;
          end
        end
        CMD: begin
          if (sample_pulse) begin
            shift_in <= rx_word[W-2:0];
            if (byte_end) begin
              bit_cnt <= '0;
              addr    <= rx_word[6:0];
              rw      <= rx_word[RW_BIT];
              if (rx_word[RW_BIT]) begin
                shift_out <= fetch(rx_word[6:0]);
                if (!addr_ok(rx_word[6:0])) err <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        DATA: begin
          if (shift_pulse) begin
            miso      <= shift_out[W-1];
            shift_out <= shift_out << 1;
          end
          if (sample_pulse) begin
            shift_in <= rx_word[W-2:0];
            if (byte_end) begin
              bit_cnt   <= '0;
              data_done <= 1'b1;
              if (!rw) begin
                if (addr_ok(addr)) begin
                  reg_wr_valid <= 1'b1;
                  reg_wr_addr  <= addr;
                  reg_wr_data  <= rx_word;
                end else begin
                  err <= 1'b1;
                end
              end
              if (AUTO_INC) begin
                addr <= next_addr;
                if (rw) begin
                  shift_out <= fetch(next_addr);
                  if (!addr_ok(next_addr)) err <= 1'b1;
                end
              end else begin
                miso <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        DRAIN: miso <= 1'b0;
        default: miso <= 1'b0;
      endcase

      if (cs_rise && state_q != IDLE) begin
        miso       <= 1'b0;
        miso_oe    <= 1'b0;
        bit_cnt    <= '0;
        frame_done <= frame_ok;
        frame_err  <= !frame_ok;
      end
    end
  end

  always_comb begin
    host_rdata = '0;
    if (addr_ok(host_addr)) host_rdata = regs[host_addr[IDX_W-1:0]];
  end

endmodule

// File: tb/tb_spi_slave_reg_responder.sv
// Bench for spi_slave_reg_responder: one instance per SPI mode 0..3, each
// driven by its own bit-banged master. Table-driven frames plus hand-written
// abort, burst and mid-frame reset sequences.
module tb_spi_slave_reg_responder;

`ifdef SPI_REG_AUTO_INC_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif

  localparam int HALF = 80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] sclk_v, cs_v, mosi_v, miso_v, oe_v, wrv_v, fd_v, fe_v;
  logic [3:0][6:0] wra_v, ha_v;
  logic [3:0][7:0] wrd_v, hrd_v;

  int tests = 0;
  int fails = 0;
  int wr_tot [4] = '{default: 0};
  int done_tot [4] = '{default: 0};
  int err_tot [4] = '{default: 0};
  logic [6:0] last_wa [4];
  logic [7:0] last_wd [4];
  logic [7:0] hr_at [4];
  logic [7:0] hr_next [4];
  logic [3:0] wrv_prev = '0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_reg_responder #(.SPI_MODE(g), .SPI_TRF_BIT(8), .NUM_REGS(16)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sclk         (sclk_v[g]),
      .cs           (cs_v[g]),
      .mosi         (mosi_v[g]),
      .miso         (miso_v[g]),
      .miso_oe      (oe_v[g]),
      .reg_wr_valid (wrv_v[g]),
      .reg_wr_addr  (wra_v[g]),
      .reg_wr_data  (wrd_v[g]),
      .host_addr    (ha_v[g]),
      .host_rdata   (hrd_v[g]),
      .frame_done   (fd_v[g]),
      .frame_err    (fe_v[g])
    );
  end

  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (wrv_prev[m]) hr_next[m] = hrd_v[m];
      wrv_prev[m] = wrv_v[m];
      if (wrv_v[m]) begin
        wr_tot[m]++;
        last_wa[m] = wra_v[m];
        last_wd[m] = wrd_v[m];
        hr_at[m]   = hrd_v[m];
      end
      if (fd_v[m]) done_tot[m]++;
      if (fe_v[m]) err_tot[m]++;
    end
  end

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] data;
    logic [7:0] rx;
    logic       wr;
    logic [7:0] old_v;
    logic [7:0] host;
    logic       done;
    logic       err;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s mode%0d: got 0x%0h want 0x%0h", name, m, act, exp);
    end
  endtask

  task automatic spi_bit(input int m, input logic b, output logic r);
    bit cp;
    cp = m[1];
    if (m[0] == 1'b0) begin
      mosi_v[m] = b;
      #HALF;
      sclk_v[m] = ~cp;
      r = miso_v[m];
      #HALF;
      sclk_v[m] = cp;
    end else begin
      sclk_v[m] = ~cp;
      mosi_v[m] = b;
      #HALF;
      sclk_v[m] = cp;
      r = miso_v[m];
      #HALF;
    end
  endtask

  task automatic spi_byte(input int m, input logic [7:0] tx, output logic [7:0] rx);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(m, tx[i], r);
      rx[i] = r;
    end
  endtask

  task automatic cs_lower(input int m);
    cs_v[m] = 1'b0;
    #HALF;
  endtask

  task automatic cs_raise(input int m);
    #HALF;
    cs_v[m] = 1'b1;
    #(HALF * 2);
  endtask

  task automatic frame2(input int m, input logic [7:0] b0, input logic [7:0] b1,
                        output logic [7:0] rx1, output logic oe_mid);
    logic [7:0] rx0;
    cs_lower(m);
    spi_byte(m, b0, rx0);
    oe_mid = oe_v[m];
    spi_byte(m, b1, rx1);
    cs_raise(m);
  endtask

  task automatic run_entry(input int m, input vec_t v);
    int w0, d0, e0;
    logic [7:0] rx;
    logic oe_mid;
    ha_v[m] = v.cmd[6:0];
    w0 = wr_tot[m];
    d0 = done_tot[m];
    e0 = err_tot[m];
    frame2(m, v.cmd, v.data, rx, oe_mid);
    @(negedge clk);
    check("miso_byte", m, rx, v.rx);
    check("oe_mid", m, oe_mid, 1);
    check("oe_after", m, oe_v[m], 0);
    check("wr_count", m, wr_tot[m] - w0, v.wr);
    if (v.wr) begin
      check("wr_addr", m, last_wa[m], v.cmd[6:0]);
      check("wr_data", m, last_wd[m], v.data);
      check("host_old_at_commit", m, hr_at[m], v.old_v);
      check("host_new_after", m, hr_next[m], v.data);
    end
    check("host_rdata", m, hrd_v[m], v.host);
    check("frame_done", m, done_tot[m] - d0, v.done);
    check("frame_err", m, err_tot[m] - e0, v.err);
  endtask

  initial begin
    logic [7:0] rx;
    logic r;
    int w0, d0, e0;
    vec_t rv;

    tbl[0] = '{8'h03, 8'hA5, 8'h00, 1'b1, 8'h00, 8'hA5, 1'b1, 1'b0};
    tbl[1] = '{8'h83, 8'h00, 8'hA5, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b0};
    tbl[2] = '{8'h95, 8'h00, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[3] = '{8'h15, 8'h3C, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[4] = '{8'h0F, 8'h5A, 8'h00, 1'b1, 8'h00, 8'h5A, 1'b1, 1'b0};
    tbl[5] = '{8'h8F, 8'h00, 8'h5A, 1'b0, 8'h00, 8'h5A, !AI, AI};
    tbl[6] = '{8'h90, 8'h00, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[7] = '{8'h03, 8'hC3, 8'h00, 1'b1, 8'hA5, 8'hC3, 1'b1, 1'b0};
    tbl[8] = '{8'h83, 8'h00, 8'hC3, 1'b0, 8'h00, 8'hC3, 1'b1, 1'b0};
    tbl[9] = '{8'h82, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};

    cs_v = 4'hF;
    mosi_v = '0;
    sclk_v = 4'b1100;
    ha_v = '0;
    #55;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int m = 0; m < 4; m++) begin
      check("rst_miso", m, miso_v[m], 0);
      check("rst_oe", m, oe_v[m], 0);
      check("rst_wr_valid", m, wrv_v[m], 0);
      check("rst_pulses", m, {fd_v[m], fe_v[m]}, 0);
      check("rst_host_rdata", m, hrd_v[m], 0);
    end

    for (int m = 0; m < 4; m++)
      for (int i = 0; i < 10; i++) run_entry(m, tbl[i]);

    // cs rises five bits into the data byte of a write
    for (int m = 0; m < 4; m++) begin
      ha_v[m] = 7'd2;
      w0 = wr_tot[m]; d0 = done_tot[m]; e0 = err_tot[m];
      cs_lower(m);
      spi_byte(m, 8'h02, rx);
      for (int i = 0; i < 5; i++) spi_bit(m, 1'b1, r);
      cs_raise(m);
      @(negedge clk);
      check("abort_wr_count", m, wr_tot[m] - w0, 0);
      check("abort_reg2", m, hrd_v[m], 8'h00);
      check("abort_done", m, done_tot[m] - d0, 0);
      check("abort_err", m, err_tot[m] - e0, 1);
    end

    // four-byte burst: one data byte only unless address auto-increment is built in
    for (int m = 0; m < 4; m++) begin
      w0 = wr_tot[m]; d0 = done_tot[m]; e0 = err_tot[m];
      cs_lower(m);
      spi_byte(m, 8'h04, rx);
      spi_byte(m, 8'h11, rx);
      spi_byte(m, 8'h22, rx);
      spi_byte(m, 8'h33, rx);
      cs_raise(m);
      @(negedge clk);
      check("burst_wr_count", m, wr_tot[m] - w0, AI ? 3 : 1);
      check("burst_last_data", m, last_wd[m], AI ? 8'h33 : 8'h11);
      check("burst_done", m, done_tot[m] - d0, 1);
      check("burst_err", m, err_tot[m] - e0, 0);
      ha_v[m] = 7'd4; @(negedge clk);
      check("burst_reg4", m, hrd_v[m], 8'h11);
      ha_v[m] = 7'd5; @(negedge clk);
      check("burst_reg5", m, hrd_v[m], AI ? 8'h22 : 8'h00);
      ha_v[m] = 7'd6; @(negedge clk);
      check("burst_reg6", m, hrd_v[m], AI ? 8'h33 : 8'h00);
    end

    // reset asserted in the middle of the data byte of a write on the mode-1 instance
    ha_v[1] = 7'd3;
    ha_v[0] = 7'd3;
    w0 = wr_tot[1]; d0 = done_tot[1]; e0 = err_tot[1];
    cs_lower(1);
    spi_byte(1, 8'h05, rx);
    spi_bit(1, 1'b1, r); spi_bit(1, 1'b0, r); spi_bit(1, 1'b0, r); spi_bit(1, 1'b1, r);
    rst_n = 1'b0;
    #30;
    check("midrst_oe", 1, oe_v[1], 0);
    check("midrst_miso", 1, miso_v[1], 0);
    check("midrst_reg3", 1, hrd_v[1], 8'h00);
    check("midrst_reg3_other", 0, hrd_v[0], 8'h00);
    rst_n = 1'b1;
    #20;
    spi_bit(1, 1'b1, r); spi_bit(1, 1'b0, r); spi_bit(1, 1'b0, r); spi_bit(1, 1'b1, r);
    cs_raise(1);
    @(negedge clk);
    check("midrst_wr_count", 1, wr_tot[1] - w0, 0);
    check("midrst_done", 1, done_tot[1] - d0, 0);
    check("midrst_err", 1, err_tot[1] - e0, 0);
    check("midrst_oe_after", 1, oe_v[1], 0);

    rv = '{8'h05, 8'h99, 8'h00, 1'b1, 8'h00, 8'h99, 1'b1, 1'b0};
    run_entry(1, rv);
    rv = '{8'h83, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    run_entry(2, rv);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
